pipelined_multiplier: RTL



---
 rtl/mul_pkg.sv | 35 +++
 rtl/multiplier_step.sv | 18 +
 rtl/pipelined_multiplier.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier.
//   OP_*      : type_i encodings
//   state_t   : controller states
//   is_signed : operation takes signed operands (SMULL/SMLAL)
//   is_long   : operation produces a 2*WIDTH result
//   is_acc    : operation adds the accumulator input(s)
package mul_pkg;

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_MLA   = 3'b001;
   localparam logic [2:0] OP_UMULL = 3'b100;
   localparam logic [2:0] OP_UMLAL = 3'b101;
   localparam logic [2:0] OP_SMULL = 3'b110;
   localparam logic [2:0] OP_SMLAL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FINAL
   } state_t;

   function automatic logic is_signed(input logic [2:0] op);
      return (op == OP_SMULL) || (op == OP_SMLAL);
   endfunction

   function automatic logic is_long(input logic [2:0] op);
      return (op == OP_UMULL) || (op == OP_UMLAL) || is_signed(op);
   endfunction

   // 010/011 fall through as plain MUL, so they never accumulate.
   function automatic logic is_acc(input logic [2:0] op);
      return (op == OP_MLA) || (op == OP_UMLAL) || (op == OP_SMLAL);
   endfunction

endpackage

// File: rtl/multiplier_step.sv
// Combinational WIDTH x BITS_PER_CYCLE partial-product generator.
//   a  : multiplicand magnitude
//   b  : current multiplier chunk
//   pp : a * b, full width
module multiplier_step #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 8
) (
   input  logic [WIDTH-1:0]                a,
   input  logic [BITS_PER_CYCLE-1:0]       b,
   output logic [WIDTH+BITS_PER_CYCLE-1:0] pp
);

   localparam int PW = WIDTH + BITS_PER_CYCLE;

   assign pp = PW'(a) * PW'(b);

endmodule

// File: rtl/pipelined_multiplier.sv
// Iterative multiplier for MUL/MLA/UMULL/UMLAL/SMULL/SMLAL, consuming
// BITS_PER_CYCLE multiplier bits per clock with a start/busy/done handshake.
//   clk_sys, reset     : clock, synchronous active-high reset
//   start_i, type_i    : request and operation type (sampled in IDLE only)
//   a_i, b_i           : multiplicand, multiplier
//   c_i, d_i           : accumulator ({c_i,d_i} for long types, c_i for MLA)
//   busy_o             : operation in flight
//   done_o             : one-cycle pulse, result_o/n_o/z_o valid
//   result_o, n_o, z_o : result and flags, held until next done_o or reset
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for start_i; operands latched on acceptance
// ST_RUN   | one multiplier chunk accumulated per cycle
// ST_FINAL | sign fix-up, accumulate, truncate, register result
module pipelined_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 8,
   parameter bit EARLY_TERM     = 1'b0
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               start_i,
   input  logic [2:0]         type_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic [WIDTH-1:0]   c_i,
   input  logic [WIDTH-1:0]   d_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] result_o,
   output logic               n_o,
   output logic               z_o
);

   localparam int STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(STEPS + 1);
   localparam int RW    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   state_t                          state, state_nxt;
   logic [2:0]                      op_q;
   logic                            sign_q;
   logic [WIDTH-1:0]                mag_a_q, mag_b_q, acc_hi_q, acc_lo_q;
   logic [RW-1:0]                   prod_q;
   logic [CNT_W-1:0]                count_q;

   logic                            sign_in;
   logic [WIDTH-1:0]                mag_a_in, mag_b_in, mag_b_shift;
   logic [CNT_W-1:0]                chunk_idx;
   logic [WIDTH+BITS_PER_CYCLE-1:0] pp;
   logic [RW-1:0]                   pp_shifted;
   logic                            last_step;
   logic [RW-1:0]                   r_signed, r_acc, r_sum, r_final;

   // Magnitudes are taken up front so the datapath is purely unsigned;
   // 2^(W-1) is representable unsigned, so the most-negative value is safe.
   assign sign_in  = is_signed(type_i) & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
   assign mag_a_in = (is_signed(type_i) && a_i[WIDTH-1]) ? -a_i : a_i;
   assign mag_b_in = (is_signed(type_i) && b_i[WIDTH-1]) ? -b_i : b_i;

   multiplier_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .a  (mag_a_q),
      .b  (mag_b_q[BITS_PER_CYCLE-1:0]),
      .pp (pp)
   );

   assign chunk_idx   = STEPS_C - count_q;
   assign pp_shifted  = RW'(pp) << (int'(chunk_idx) * BITS_PER_CYCLE);
   assign mag_b_shift = mag_b_q >> BITS_PER_CYCLE;
   assign last_step   = (count_q == ONE_C) || (EARLY_TERM && (mag_b_shift == '0));

   assign r_signed = sign_q ? -prod_q : prod_q;
   assign r_acc    = is_long(op_q) ? {acc_hi_q, acc_lo_q} : {{WIDTH{1'b0}}, acc_hi_q};
   assign r_sum    = r_signed + (is_acc(op_q) ? r_acc : '0);
   assign r_final  = is_long(op_q) ? r_sum : {{WIDTH{1'b0}}, r_sum[WIDTH-1:0]};

   assign busy_o = (state != ST_IDLE);

   always_ff @(posedge clk_sys) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_i) state_nxt = ST_RUN;
         ST_RUN:   if (last_step) state_nxt = ST_FINAL;
         ST_FINAL: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         op_q     <= '0;
         sign_q   <= 1'b0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         prod_q   <= '0;
         count_q  <= '0;
         done_o   <= 1'b0;
         result_o <= '0;
         n_o      <= 1'b0;
         z_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  op_q     <= type_i;
                  sign_q   <= sign_in;
                  mag_a_q  <= mag_a_in;
                  mag_b_q  <= mag_b_in;
                  acc_hi_q <= c_i;
                  acc_lo_q <= d_i;
                  prod_q   <= '0;
                  count_q  <= STEPS_C;
               end
            end
            ST_RUN: begin
               prod_q  <= prod_q + pp_shifted;
               mag_b_q <= mag_b_shift;
               count_q <= count_q - ONE_C;
            end
            ST_FINAL: begin
               result_o <= r_final;
               n_o      <= is_long(op_q) ? r_final[RW-1] : r_final[WIDTH-1];
               z_o      <= (r_final == '0);
               done_o   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
